// File: rtl/counter_sched.sv
// Round-robin scheduler sharing one down-counting interval timer among NREQ requesters.
// Latency: grant one cycle after a request is seen in IDLE; done pulses L+1 cycles after grant.
// Backpressure: requests wait at their level until granted; dropping req while owning cancels the run.
module counter_sched #(
  parameter int NREQ  = 4,
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [NREQ*WIDTH-1:0] len,
  output logic [NREQ-1:0]       gnt,
  output logic                  busy,
  output logic [WIDTH-1:0]      cnt,
  output logic [NREQ-1:0]       done
);

  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e                     state_q, state_d;
  logic [NREQ-1:0]            gnt_q, gnt_d;
  logic [NREQ-1:0]            done_q, done_d;
  logic [WIDTH-1:0]           cnt_q, cnt_d;
  // ptr doubles as the owner index while a run is in progress
  logic [PW-1:0]              ptr_q, ptr_d;

  logic [NREQ-1:0][WIDTH-1:0] len_a;
  logic                       any_req;
  logic                       tc;
  logic                       owner_req;
  logic [PW-1:0]              win;
  logic                       win_found;
  logic [PW:0]                idx;

  assign len_a     = len;
  assign any_req   = |req;
  assign tc        = (cnt_q == '0);
  assign owner_req = req[ptr_q];

  // Round-robin pick: first requester found searching upward from ptr+1 with wrap
  always_comb begin
    win       = ptr_q;
    win_found = 1'b0;
    idx       = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = {1'b0, ptr_q} + (PW+1)'(k);
      if (idx >= (PW+1)'(NREQ)) begin
        idx = idx - (PW+1)'(NREQ);
      end
      if (!win_found && req[idx[PW-1:0]]) begin
        win       = idx[PW-1:0];
        win_found = 1'b1;
      end
    end
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      cnt_q   <= '0;
      ptr_q   <= PW'(NREQ-1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      ptr_q   <= ptr_d;
    end
  end

  // Next-state: terminal count takes priority over cancel; DONE always returns to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (any_req) state_d = S_RUN;
      S_RUN: begin
        if (tc) begin
          state_d = S_DONE;
        end else if (!owner_req) begin
          state_d = S_IDLE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs for each state
  always_comb begin
    gnt_d  = gnt_q;
    cnt_d  = cnt_q;
    done_d = '0;
    ptr_d  = ptr_q;
    case (state_q)
      S_IDLE: begin
        gnt_d = '0;
        cnt_d = '0;
        if (any_req) begin
          gnt_d[win] = 1'b1;
          cnt_d      = len_a[win];
          ptr_d      = win;
        end
      end
      S_RUN: begin
        if (tc) begin
          done_d = gnt_q;
          gnt_d  = '0;
        end else if (!owner_req) begin
          gnt_d = '0;
          cnt_d = '0;
        end else begin
          cnt_d = cnt_q - WIDTH'(1);
        end
      end
      default: begin
        gnt_d = '0;
        cnt_d = '0;
      end
    endcase
  end

  assign gnt  = gnt_q;
  assign done = done_q;
  assign cnt  = cnt_q;
  assign busy = (state_q != S_IDLE);

endmodule

// File: tb/tb_counter_sched.sv
// Bench for counter_sched: directed scenarios plus random requester agents.
// A cycle-level reference model pushes expected outputs; a negedge monitor pops and compares.
module tb_counter_sched;

  localparam int NREQ = 4;
  localparam int W    = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic [NREQ-1:0]      req = '0;
  logic [NREQ*W-1:0]    len = '0;
  logic [NREQ-1:0]      gnt;
  logic [NREQ-1:0]      done;
  logic                 busy;
  logic [W-1:0]         cnt;

  counter_sched #(.NREQ(NREQ), .WIDTH(W)) dut (
    .clk  (clk),
    .rst  (rst),
    .req  (req),
    .len  (len),
    .gnt  (gnt),
    .busy (busy),
    .cnt  (cnt),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [NREQ-1:0] gnt;
    logic            busy;
    logic [W-1:0]    cnt;
    logic [NREQ-1:0] done;
  } obs_t;

  obs_t exp_q[$];
  int   n_chk  = 0;
  int   n_pass = 0;
  int   ecnt   = 0;

  // Reference model state: owner of the current interval, the edge it was granted on and its length
  int m_owner     = -1;
  int m_g         = 0;
  int m_L         = 0;
  int m_ptr       = NREQ-1;
  int m_done_edge = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_len(input int i, input int v);
    len[i*W +: W] = W'(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic wait_done(input int i);
    for (int k = 0; k < 60; k++) begin
      tick();
      if (done[i]) break;
    end
    chk("wait_done", 32'(done[i]), 32'd1);
  endtask

  // Reference model: the interval granted at edge g with length L shows cnt = L-(e-g)
  // after edge e, reaches terminal count at edge g+L, and pulses done one edge later.
  always @(posedge clk) begin
    obs_t x;
    int   rem;
    ecnt++;
    x = '0;
    if (rst) begin
      m_owner     = -1;
      m_ptr       = NREQ-1;
      m_done_edge = -10;
    end else if (m_owner >= 0) begin
      rem = m_L - (ecnt - 1 - m_g);
      if (rem == 0) begin
        x.done      = NREQ'(1) << m_owner;
        x.busy      = 1'b1;
        m_done_edge = ecnt;
        m_owner     = -1;
      end else if (!req[m_owner]) begin
        m_owner = -1;
      end else begin
        x.gnt  = NREQ'(1) << m_owner;
        x.busy = 1'b1;
        x.cnt  = W'(rem - 1);
      end
    end else if (ecnt != m_done_edge + 1 && req != '0) begin
      for (int k = 1; k <= NREQ; k++) begin
        if (req[(m_ptr + k) % NREQ]) begin
          m_owner = (m_ptr + k) % NREQ;
          break;
        end
      end
      m_ptr  = m_owner;
      m_g    = ecnt;
      m_L    = int'(len[m_owner*W +: W]);
      x.gnt  = NREQ'(1) << m_owner;
      x.busy = 1'b1;
      x.cnt  = W'(m_L);
    end
    exp_q.push_back(x);
  end

  // Monitor: compare DUT outputs against the oldest expected entry
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {gnt, busy, cnt, done};
      n_chk++;
      if (a === e) n_pass++;
      else $display("FAIL sb edge %0d: got gnt=%b busy=%b cnt=%0d done=%b, expected gnt=%b busy=%b cnt=%0d done=%b",
                    ecnt, a.gnt, a.busy, a.cnt, a.done, e.gnt, e.busy, e.cnt, e.done);
    end
  end

  initial begin
    int          gs[NREQ];
    logic [NREQ-1:0] pg;
    logic [NREQ-1:0] seen_done;

    // Reset state
    tick();
    tick();
    chk("reset_outputs", 32'({gnt, busy, cnt, done}), 32'd0);
    rst = 1'b0;

    // Single request, len 3
    req = 4'b0001;
    set_len(0, 3);
    for (int c = 1; c <= 6; c++) begin
      tick();
      if (c <= 4) begin
        chk("single_gnt", 32'(gnt), 32'd1);
        chk("single_cnt", 32'(cnt), 32'(4 - c));
      end
      if (c == 5) begin
        chk("single_done", 32'(done), 32'd1);
        chk("single_gnt_clr", 32'(gnt), 32'd0);
        req = '0;
      end
      if (c == 6) chk("single_busy_low", 32'(busy), 32'd0);
    end

    // Round-robin over all four requesters, len 1
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < NREQ; i++) begin
      set_len(i, 1);
      gs[i] = -1;
    end
    pg = '0;
    for (int c = 1; c <= 16; c++) begin
      tick();
      for (int i = 0; i < NREQ; i++) begin
        if (gnt[i] && !pg[i]) gs[i] = c;
        if (done[i]) req[i] = 1'b0;
      end
      pg = gnt;
    end
    for (int i = 0; i < NREQ; i++) chk("rr_grant_cycle", 32'(gs[i]), 32'(1 + 4*i));

    // Zero length on requester 2
    req = 4'b0100;
    set_len(2, 0);
    tick();
    chk("zero_gnt", 32'(gnt), 32'b0100);
    chk("zero_cnt", 32'(cnt), 32'd0);
    tick();
    chk("zero_done", 32'(done), 32'b0100);
    chk("zero_gnt_clr", 32'(gnt), 32'd0);
    req = '0;
    tick();

    // Cancel on requester 1, then ptr=1 makes requester 0 win 4'b0011
    req = 4'b0010;
    set_len(1, 10);
    for (int c = 1; c <= 4; c++) tick();
    req[1] = 1'b0;
    tick();
    chk("cancel_gnt", 32'(gnt), 32'd0);
    chk("cancel_busy", 32'(busy), 32'd0);
    chk("cancel_cnt", 32'(cnt), 32'd0);
    seen_done = done;
    for (int c = 0; c < 3; c++) begin
      tick();
      seen_done = seen_done | done;
    end
    chk("cancel_no_done", 32'(seen_done), 32'd0);
    req = 4'b0011;
    set_len(0, 2);
    tick();
    chk("cancel_next_winner", 32'(gnt), 32'b0001);
    wait_done(0);
    req = '0;
    tick();
    tick();

    // Cancel coincident with terminal count still produces done
    req = 4'b1000;
    set_len(3, 2);
    for (int c = 1; c <= 3; c++) tick();
    chk("tc_cnt_zero", 32'(cnt), 32'd0);
    req = '0;
    tick();
    chk("tc_done", 32'(done), 32'b1000);
    tick();

    // Reset in the middle of a len 8 run
    req = 4'b0100;
    set_len(2, 8);
    for (int c = 1; c <= 3; c++) tick();
    rst = 1'b1;
    req = '0;
    tick();
    chk("midrst_outputs", 32'({gnt, busy, cnt, done}), 32'd0);
    rst = 1'b0;
    tick();
    chk("midrst_no_done", 32'(done), 32'd0);
    req = 4'b1000;
    set_len(3, 1);
    tick();
    chk("midrst_req3", 32'(gnt), 32'b1000);
    wait_done(3);
    req = '0;
    tick();
    do_reset();
    req = 4'b1001;
    tick();
    chk("midrst_req0_first", 32'(gnt), 32'b0001);
    req = '0;
    tick();
    tick();

    // Random agents: hold req until done, occasional cancels, re-requests and resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      tick();
      rst = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < NREQ; i++) begin
        if (req[i]) begin
          if (done[i]) req[i] = ($urandom_range(0, 7) == 0);
          else if (gnt[i] && $urandom_range(0, 19) == 0) req[i] = 1'b0;
        end else if ($urandom_range(0, 3) == 0) begin
          req[i] = 1'b1;
        end
        set_len(i, int'($urandom_range(0, 6)));
      end
    end
    rst = 1'b0;
    req = '0;
    for (int c = 0; c < 12; c++) tick();
    @(negedge clk);
    #1;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
